rv_pipe_ctrl: RTL and testbench
===============================

// Module: rv_pipe_ctrl
// PURPOSE
//  Central pipeline sequencer for the FlexRV32 core. Generates the stall, flush and ready controls
//  consumed by the fetch, decode, exec and exec2 stages and by the tracer (exec_flush, exec_stall,
//  exec2_flush, exec2_ready). Resolves load-use hazards, multi-cycle exec2 ops, branch and trap
//  redirects, and the post-reset pipeline purge from one FSM.
// PARAMETERS
//  RESET_FLUSH_CYCLES  3   cycles all stages are flushed after reset (>=1)
//  REDIRECT_SHADOW     1   extra cycles exec_flush stays high after a redirect (fetch latency, 0..7)
//  WDT_BITS            16  width of the exec2-busy watchdog counter
//  COUNTER_WIDTH       32  width of the performance counters
// PORTS
//  i_clk            in   1   core clock
//  i_reset          in   1   reset, synchronous, active-high
//  i_load_hazard    in   1   decode reads the rd of a load now in exec
//  i_exec2_busy     in   1   exec2 multi-cycle op (mul/div/mem wait) not complete
//  i_branch_taken   in   1   exec resolved a taken branch/jal/jalr this cycle
//  i_trap           in   1   exec2 raises trap/mret redirect this cycle
//  o_fetch_stall    out  1   hold PC and fetch output
//  o_decode_stall   out  1   hold decode register
//  o_exec_stall     out  1   hold exec register
//  o_exec_flush     out  1   load bubble into exec
//  o_exec2_flush    out  1   load bubble into exec2
//  o_exec2_ready    out  1   exec2 advances into write-back
//  o_pc_redirect    out  1   one-cycle pulse: fetch takes redirect target
//  o_redirect_src   out  1   0 = branch, 1 = trap; valid with o_pc_redirect
//  o_hang           out  1   sticky: exec2 busy for 2^WDT_BITS-1 consecutive cycles
//  o_stall_cycles   out  CW  cycles with o_exec_stall=1 (see CONFIGURATION)
//  o_flush_events   out  CW  count of o_pc_redirect pulses (see CONFIGURATION)
// BEHAVIOUR
//  - Outputs are combinational from state + inputs; state/counters are registered.
//  - States: INIT, RUN, SHADOW, HOLD. Reset (any cycle, mid-operation included) -> INIT,
//    cnt=RESET_FLUSH_CYCLES-1, watchdog=0, o_hang=0, perf counters=0.
//  - INIT: fetch_stall=1, exec_flush=1, exec2_flush=1, exec2_ready=0, redirect=0; all inputs ignored.
//    cnt decrements; cnt==0 -> RUN. These are the reset values of all outputs.
//  - RUN, priority high->low:
//    1 i_trap: exec_flush=1, exec2_flush=1, exec2_ready=1, redirect=1, src=1; -> SHADOW (or RUN if SHADOW=0).
//    2 i_exec2_busy: fetch/decode/exec_stall=1, exec2_ready=0; -> HOLD.
//    3 i_branch_taken: exec_flush=1, exec2_ready=1, redirect=1, src=0; -> SHADOW (or RUN).
//    4 i_load_hazard: fetch_stall=1, decode_stall=1, exec_flush=1, exec2_ready=1 (1-cycle bubble).
//    5 none: all stalls/flushes 0, exec2_ready=1.
//  - SHADOW: exec_flush=1, exec2_ready=1; i_branch_taken and i_load_hazard ignored (wrong-path).
//    Trap handled as RUN rule 1 and reloads cnt. Busy: stalls as rule 2, cnt frozen, exec_flush stays 1.
//    Else cnt decrements; cnt==0 -> RUN. Entry loads cnt=REDIRECT_SHADOW-1.
//  - HOLD: busy=1 -> stalls as rule 2, watchdog++ saturating; at all-ones o_hang<=1 (sticky to reset).
//    Trap overrides busy (rule 1). busy=0 -> outputs/transitions identical to RUN, watchdog<=0.
//  - o_pc_redirect never asserts on two consecutive cycles except trap-in-SHADOW.
// CONFIGURATION
//  RV_PIPE_PERF_EN defined: o_stall_cycles/o_flush_events count, wrap at 2^COUNTER_WIDTH, clear on reset.
//  Not defined: counters not built; both ports driven '0.
// TESTING
//  - Reset 1 cycle, RESET_FLUSH_CYCLES=3 -> exec_flush=1 for exactly 3 cycles, exec2_ready=1 on 4th.
//  - RUN, load_hazard 1 cycle -> fetch/decode_stall=1, exec_flush=1 that cycle only, back to 0 next.
//  - branch_taken in RUN, SHADOW=1 -> redirect pulse src=0, exec_flush=1 for 2 cycles; branch in 2nd ignored.
//  - busy held 5 cycles with load_hazard=1 -> exec_stall=1, exec2_ready=0 for 5 cycles, no bubble, then RUN.
//  - busy + trap same cycle in HOLD -> redirect=1 src=1, exec2_flush=1, state SHADOW.
//  - WDT_BITS=4, busy held 20 cycles -> o_hang=1 from 15th busy cycle, stays 1 after busy drops, clears on reset.

Source files
------------

// File: rtl/rv_pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// rv_pipe_ctrl_if
//   Bundles the hazard/redirect requests coming from the pipeline stages and
//   the stall/flush/ready controls going back to them. The sequencer uses the
//   slave view. The stages (or a testbench) use the master view.
//
//   Requests  (master -> slave): i_load_hazard, i_exec2_busy, i_branch_taken,
//                                i_trap
//   Controls  (slave -> master): o_fetch_stall, o_decode_stall, o_exec_stall,
//                                o_exec_flush, o_exec2_flush, o_exec2_ready,
//                                o_pc_redirect, o_redirect_src, o_hang
//   Perf      (slave -> master): o_stall_cycles, o_flush_events
//                                (COUNTER_WIDTH bits each)
// ---------------------------------------------------------------------------
interface rv_pipe_ctrl_if #(
  parameter int COUNTER_WIDTH = 32
);
  logic                     i_load_hazard;
  logic                     i_exec2_busy;
  logic                     i_branch_taken;
  logic                     i_trap;

  logic                     o_fetch_stall;
  logic                     o_decode_stall;
  logic                     o_exec_stall;
  logic                     o_exec_flush;
  logic                     o_exec2_flush;
  logic                     o_exec2_ready;
  logic                     o_pc_redirect;
  logic                     o_redirect_src;
  logic                     o_hang;
  logic [COUNTER_WIDTH-1:0] o_stall_cycles;
  logic [COUNTER_WIDTH-1:0] o_flush_events;

  modport slave (
    input  i_load_hazard, i_exec2_busy, i_branch_taken, i_trap,
    output o_fetch_stall, o_decode_stall, o_exec_stall, o_exec_flush,
           o_exec2_flush, o_exec2_ready, o_pc_redirect, o_redirect_src,
           o_hang, o_stall_cycles, o_flush_events
  );

  modport master (
    output i_load_hazard, i_exec2_busy, i_branch_taken, i_trap,
    input  o_fetch_stall, o_decode_stall, o_exec_stall, o_exec_flush,
           o_exec2_flush, o_exec2_ready, o_pc_redirect, o_redirect_src,
           o_hang, o_stall_cycles, o_flush_events
  );
endinterface

// File: rtl/rv_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// rv_pipe_ctrl
//   Central pipeline sequencer for the FlexRV32 core. One FSM (INIT, RUN,
//   SHADOW, HOLD) produces the stall, flush and ready controls for the fetch,
//   decode, exec and exec2 stages. It resolves load-use hazards, multi-cycle
//   exec2 ops, branch/trap redirects and the post-reset pipeline purge.
//
// Ports
//   i_clk    core clock
//   i_reset  synchronous, active-high reset
//   pif      rv_pipe_ctrl_if.slave; carries the hazard/redirect requests in
//            and the stall/flush/ready/redirect controls, the sticky watchdog
//            flag and the perf counters out
//
// Parameters
//   RESET_FLUSH_CYCLES  cycles every stage is flushed after reset (>=1)
//   REDIRECT_SHADOW     extra exec_flush cycles after a redirect (0..7)
//   WDT_BITS            width of the exec2-busy watchdog
//   COUNTER_WIDTH       width of the perf counters (match the interface)
//
// Configuration macro
//   RV_PIPE_PERF_EN     builds the stall-cycle and redirect-event counters.
//                       Without it both counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module rv_pipe_ctrl #(
  parameter int RESET_FLUSH_CYCLES = 3,
  parameter int REDIRECT_SHADOW    = 1,
  parameter int WDT_BITS           = 16,
  parameter int COUNTER_WIDTH      = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  rv_pipe_ctrl_if.slave pif
);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SHADOW = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // One down-counter serves both the reset purge and the redirect shadow.
  // It must hold the larger of the two load values.
  localparam int CNT_MAX = (RESET_FLUSH_CYCLES > REDIRECT_SHADOW) ?
                           RESET_FLUSH_CYCLES : REDIRECT_SHADOW;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] INIT_LOAD   = CNT_W'(RESET_FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHADOW_LOAD =
    CNT_W'((REDIRECT_SHADOW > 0) ? REDIRECT_SHADOW - 1 : 0);

  // With no shadow a redirect returns straight to RUN.
  localparam logic [1:0] REDIRECT_STATE = (REDIRECT_SHADOW > 0) ? ST_SHADOW : ST_RUN;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WDT_BITS-1:0] wdt_q, wdt_d;
  logic                hang_q, hang_d;

  logic fetch_stall, decode_stall, exec_stall;
  logic exec_flush, exec2_flush, exec2_ready;
  logic pc_redirect, redirect_src;
  logic hang_now;

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wdt_d        = '0;
    fetch_stall  = 1'b0;
    decode_stall = 1'b0;
    exec_stall   = 1'b0;
    exec_flush   = 1'b0;
    exec2_flush  = 1'b0;
    exec2_ready  = 1'b0;
    pc_redirect  = 1'b0;
    redirect_src = 1'b0;

    if (i_reset) begin
      // Reset values: the whole pipe is held and bubbled.
      fetch_stall = 1'b1;
      exec_flush  = 1'b1;
      exec2_flush = 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          // Purge: every request input is ignored.
          fetch_stall = 1'b1;
          exec_flush  = 1'b1;
          exec2_flush = 1'b1;
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end

        // HOLD behaves exactly like RUN except that it keeps the watchdog
        // running while exec2 stays busy.
        ST_RUN, ST_HOLD: begin
          state_d = ST_RUN;
          if (pif.i_trap) begin
            exec_flush   = 1'b1;
            exec2_flush  = 1'b1;
            exec2_ready  = 1'b1;
            pc_redirect  = 1'b1;
            redirect_src = 1'b1;
            state_d      = REDIRECT_STATE;
            cnt_d        = SHADOW_LOAD;
          end else if (pif.i_exec2_busy) begin
            // Freeze the front of the pipe; a pending load hazard is
            // resolved by the freeze itself, so no bubble is inserted.
            fetch_stall  = 1'b1;
            decode_stall = 1'b1;
            exec_stall   = 1'b1;
            state_d      = ST_HOLD;
            wdt_d        = (&wdt_q) ? wdt_q : wdt_q + 1'b1;
          end else if (pif.i_branch_taken) begin
            exec_flush   = 1'b1;
            exec2_ready  = 1'b1;
            pc_redirect  = 1'b1;
            state_d      = REDIRECT_STATE;
            cnt_d        = SHADOW_LOAD;
          end else if (pif.i_load_hazard) begin
            // One-cycle bubble: decode re-presents the dependent op next cycle.
            fetch_stall  = 1'b1;
            decode_stall = 1'b1;
            exec_flush   = 1'b1;
            exec2_ready  = 1'b1;
          end else begin
            exec2_ready  = 1'b1;
          end
        end

        ST_SHADOW: begin
          // Whatever reaches exec now is wrong-path, so branch and hazard
          // requests are meaningless and exec keeps receiving bubbles.
          exec_flush = 1'b1;
          if (pif.i_trap) begin
            exec2_flush  = 1'b1;
            exec2_ready  = 1'b1;
            pc_redirect  = 1'b1;
            redirect_src = 1'b1;
            cnt_d        = SHADOW_LOAD;
          end else if (pif.i_exec2_busy) begin
            fetch_stall  = 1'b1;
            decode_stall = 1'b1;
            exec_stall   = 1'b1;
          end else begin
            exec2_ready = 1'b1;
            if (cnt_q == '0) state_d = ST_RUN;
            else             cnt_d   = cnt_q - 1'b1;
          end
        end

        default: begin
          state_d = ST_INIT;
          cnt_d   = INIT_LOAD;
        end
      endcase
    end
  end

  // The watchdog counts the busy cycle that enters HOLD plus every busy cycle
  // spent in HOLD. The hang flag is raised in the very cycle the count
  // reaches all-ones, then held in hang_q until reset.
  assign hang_now = &wdt_d;
  assign hang_d   = hang_q | hang_now;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the clock edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_INIT;
      cnt_q   <= INIT_LOAD;
      wdt_q   <= '0;
      hang_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdt_q   <= wdt_d;
      hang_q  <= hang_d;
    end
  end

  assign pif.o_fetch_stall  = fetch_stall;
  assign pif.o_decode_stall = decode_stall;
  assign pif.o_exec_stall   = exec_stall;
  assign pif.o_exec_flush   = exec_flush;
  assign pif.o_exec2_flush  = exec2_flush;
  assign pif.o_exec2_ready  = exec2_ready;
  assign pif.o_pc_redirect  = pc_redirect;
  assign pif.o_redirect_src = redirect_src;
  assign pif.o_hang         = (hang_q & ~i_reset) | hang_now;

`ifdef RV_PIPE_PERF_EN
  logic [COUNTER_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [COUNTER_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Free-running, wrapping counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q + COUNTER_WIDTH'(exec_stall);
    flush_cnt_d = flush_cnt_q + COUNTER_WIDTH'(pc_redirect);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pif.o_stall_cycles = stall_cnt_q;
  assign pif.o_flush_events = flush_cnt_q;
`else
  logic [COUNTER_WIDTH-1:0] perf_zero;
  assign perf_zero          = '0;
  assign pif.o_stall_cycles = perf_zero;
  assign pif.o_flush_events = perf_zero;
`endif

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_pipe_ctrl
//   Self-checking bench for rv_pipe_ctrl (RESET_FLUSH_CYCLES=3,
//   REDIRECT_SHADOW=1, WDT_BITS=4, COUNTER_WIDTH=8). A directed vector table
//   is followed by a watchdog sequence and randomized traffic compared
//   against a rule-level reference model.
// ---------------------------------------------------------------------------
module tb_rv_pipe_ctrl;
  localparam int RFC     = 3;
  localparam int RS      = 1;
  localparam int WDT     = 4;
  localparam int CW      = 8;
  localparam int WDT_MAX = (1 << WDT) - 1;

  // Control vector bit order:
  // {fetch_stall, decode_stall, exec_stall, exec_flush,
  //  exec2_flush, exec2_ready, pc_redirect, redirect_src}
  localparam logic [7:0] V_INIT   = 8'b1001_1000;
  localparam logic [7:0] V_IDLE   = 8'b0000_0100;
  localparam logic [7:0] V_HAZ    = 8'b1101_0100;
  localparam logic [7:0] V_BRANCH = 8'b0001_0110;
  localparam logic [7:0] V_TRAP   = 8'b0001_1111;
  localparam logic [7:0] V_BUSY   = 8'b1110_0000;
  localparam logic [7:0] V_SHIDLE = 8'b0001_0100;
  localparam logic [7:0] V_SHBUSY = 8'b1111_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_pipe_ctrl_if #(.COUNTER_WIDTH(CW)) pif ();

  rv_pipe_ctrl #(
    .RESET_FLUSH_CYCLES(RFC),
    .REDIRECT_SHADOW   (RS),
    .WDT_BITS          (WDT),
    .COUNTER_WIDTH     (CW)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .pif    (pif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The pipe is either purging after reset, running normally (the
  // sequencer's RUN/HOLD distinction only matters for the watchdog streak)
  // or in a wrong-path shadow of known remaining length.
  typedef enum {M_INIT, M_NORMAL, M_SHADOW} mode_e;
  mode_e m_mode    = M_INIT;
  int    m_left    = 0;
  int    m_streak  = 0;
  bit    m_hang    = 1'b0;
  int    m_stalls  = 0;
  int    m_flushes = 0;

  task automatic model_step(input bit r, hz, bs, br, tp,
                            output logic [7:0] ctl, output bit hang);
    bit stalled = 1'b0;
    ctl  = V_IDLE;
    hang = 1'b0;
    if (r) begin
      ctl = V_INIT; m_mode = M_INIT; m_left = RFC;
      m_streak = 0; m_hang = 1'b0; m_stalls = 0; m_flushes = 0;
      return;
    end
    case (m_mode)
      M_INIT: begin
        ctl = V_INIT;
        m_left--;
        if (m_left == 0) m_mode = M_NORMAL;
      end
      M_NORMAL: begin
        if (tp)      begin ctl = V_TRAP;   if (RS > 0) begin m_mode = M_SHADOW; m_left = RS; end end
        else if (bs) begin ctl = V_BUSY;   stalled = 1'b1; end
        else if (br) begin ctl = V_BRANCH; if (RS > 0) begin m_mode = M_SHADOW; m_left = RS; end end
        else if (hz) ctl = V_HAZ;
        else         ctl = V_IDLE;
      end
      default: begin
        if (tp)      begin ctl = V_TRAP; m_left = RS; end
        else if (bs) ctl = V_SHBUSY;
        else begin
          ctl = V_SHIDLE;
          m_left--;
          if (m_left == 0) m_mode = M_NORMAL;
        end
      end
    endcase
    m_streak = stalled ? ((m_streak + 1 > WDT_MAX) ? WDT_MAX : m_streak + 1) : 0;
    hang     = m_hang || (m_streak == WDT_MAX);
    m_hang   = hang;
    m_stalls  += int'(ctl[5]);
    m_flushes += int'(ctl[1]);
  endtask

  // Drive one cycle, sample between edges, compare. When use_tab is set the
  // control vector is compared against the table entry, otherwise the model.
  task automatic step(input bit r, hz, bs, br, tp, input bit use_tab,
                      input logic [7:0] tab_ctl, input string name);
    logic [7:0] act, exp, m_ctl, msk;
    bit         m_hang_exp;
    int         exp_st, exp_fl;
    @(negedge clk);
    rst = r;
    pif.i_load_hazard  = hz;
    pif.i_exec2_busy   = bs;
    pif.i_branch_taken = br;
    pif.i_trap         = tp;
    #1;
    act = {pif.o_fetch_stall, pif.o_decode_stall, pif.o_exec_stall, pif.o_exec_flush,
           pif.o_exec2_flush, pif.o_exec2_ready, pif.o_pc_redirect, pif.o_redirect_src};
    if (!r) begin
`ifdef RV_PIPE_PERF_EN
      exp_st = m_stalls  % (1 << CW);
      exp_fl = m_flushes % (1 << CW);
`else
      exp_st = 0;
      exp_fl = 0;
`endif
      check({name, "_stall_cycles"}, 32'(pif.o_stall_cycles), exp_st);
      check({name, "_flush_events"}, 32'(pif.o_flush_events), exp_fl);
    end
    model_step(r, hz, bs, br, tp, m_ctl, m_hang_exp);
    exp = use_tab ? tab_ctl : m_ctl;
    // redirect_src only carries meaning alongside a redirect pulse
    msk = exp[1] ? 8'hFF : 8'hFE;
    check({name, "_ctl"}, act & msk, exp & msk);
    check({name, "_hang"}, pif.o_hang, m_hang_exp);
  endtask

  typedef struct {
    bit         r, hz, bs, br, tp;
    logic [7:0] ctl;
    string      name;
  } vec_t;

  vec_t tab[$];

  initial begin
    bit busy_r = 1'b0;

    //              r  hz bs br tp  expected   name
    tab.push_back('{1, 0, 0, 0, 0, V_INIT,   "reset"});
    tab.push_back('{0, 1, 1, 1, 1, V_INIT,   "init1_ignores_inputs"});
    tab.push_back('{0, 0, 0, 0, 0, V_INIT,   "init2"});
    tab.push_back('{0, 0, 0, 0, 0, V_INIT,   "init3"});
    tab.push_back('{0, 0, 0, 0, 0, V_IDLE,   "run_first"});
    tab.push_back('{0, 1, 0, 0, 0, V_HAZ,    "load_hazard"});
    tab.push_back('{0, 0, 0, 0, 0, V_IDLE,   "after_hazard"});
    tab.push_back('{0, 0, 0, 1, 0, V_BRANCH, "branch"});
    tab.push_back('{0, 1, 0, 1, 0, V_SHIDLE, "shadow_ignores_branch"});
    tab.push_back('{0, 0, 0, 0, 0, V_IDLE,   "after_shadow"});
    for (int i = 0; i < 5; i++)
      tab.push_back('{0, 1, 1, 0, 0, V_BUSY, "busy_with_hazard"});
    tab.push_back('{0, 1, 0, 0, 0, V_HAZ,    "hold_release_hazard"});
    tab.push_back('{0, 0, 0, 0, 0, V_IDLE,   "run_again"});
    tab.push_back('{0, 0, 1, 0, 0, V_BUSY,   "enter_hold"});
    tab.push_back('{0, 0, 1, 0, 1, V_TRAP,   "hold_busy_trap"});
    tab.push_back('{0, 0, 1, 0, 0, V_SHBUSY, "shadow_busy"});
    tab.push_back('{0, 0, 0, 0, 1, V_TRAP,   "shadow_trap"});
    tab.push_back('{0, 0, 0, 0, 0, V_SHIDLE, "shadow_after_trap"});
    tab.push_back('{0, 0, 0, 0, 0, V_IDLE,   "run_final"});

    foreach (tab[i])
      step(tab[i].r, tab[i].hz, tab[i].bs, tab[i].br, tab[i].tp, 1'b1, tab[i].ctl, tab[i].name);

    // Watchdog: busy for 20 cycles, hang from the 15th, sticky until reset.
    step(1, 0, 0, 0, 0, 1'b1, V_INIT, "wdt_reset");
    for (int i = 0; i < RFC; i++) step(0, 0, 0, 0, 0, 1'b1, V_INIT, "wdt_init");
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 1, 0, 0, 1'b1, V_BUSY, "wdt_busy");
      check("wdt_hang_direct", pif.o_hang, (k >= WDT_MAX) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1'b1, V_IDLE, "wdt_after_busy");
      check("wdt_hang_sticky", pif.o_hang, 1);
    end
    step(1, 0, 0, 0, 0, 1'b1, V_INIT, "wdt_clear_reset");
    check("wdt_hang_cleared", pif.o_hang, 0);
    step(0, 0, 0, 0, 0, 1'b1, V_INIT, "wdt_post_reset");
    check("wdt_hang_post_reset", pif.o_hang, 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      bit r, hz, br, tp;
      if ($urandom_range(0, 99) < 15) busy_r = ~busy_r;
      r  = ($urandom_range(0, 99) < 1);
      hz = ($urandom_range(0, 99) < 30);
      br = ($urandom_range(0, 99) < 20);
      tp = ($urandom_range(0, 99) < 8);
      step(r, hz, busy_r, br, tp, 1'b0, 8'h00, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
